// File: rtl/wb_arb_pkg.sv
// Shared encodings for the two-master Wishbone round-robin arbiter:
// FSM state codes and one-hot grant values.
package wb_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_timeout.sv
// Stalled-strobe watchdog for the arbiter; counts owner cycles with stb high
// and no ack/err, and flags expiry on the TIMEOUT_CYCLES-th such cycle.
module wb_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic own,
    input  logic stb,
    input  logic ack,
    input  logic err,
    output logic clear,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign clear  = ~own | ~stb | ack | err;
    assign expire = ~clear & (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/wb_rr_arbiter2.sv
// Two-master Wishbone B3 classic round-robin arbiter, grant held per CYC.
// Optional stalled-strobe timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter2 #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic              m0_we_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic              m1_we_i,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic              s_we_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    output logic [1:0]        grant_o
);

    import wb_arb_pkg::*;

    logic [1:0] state, state_nxt;
    logic       ptr, ptr_nxt;
    logic       own0, own1;
    logic       req0, req1;
    logic       expire;

    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);

`ifdef WB_ARB_TIMEOUT_EN
    logic hold0, hold1;
    logic unused_to_clear;

    wb_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .own    (own0 | own1),
        .stb    (own1 ? m1_stb_i : m0_stb_i),
        .ack    (s_ack_i),
        .err    (s_err_i),
        .clear  (unused_to_clear),
        .expire (expire)
    );

    // A timed-out master is ignored until it has dropped cyc for a cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            hold0 <= 1'b0;
            hold1 <= 1'b0;
        end else begin
            hold0 <= (expire & own0) | (hold0 & m0_cyc_i);
            hold1 <= (expire & own1) | (hold1 & m1_cyc_i);
        end
    end

    assign req0 = m0_cyc_i & ~hold0;
    assign req1 = m1_cyc_i & ~hold1;
`else
    logic unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES[0];
    assign expire         = 1'b0;
    assign req0           = m0_cyc_i;
    assign req1           = m1_cyc_i;
`endif

    // ptr=0 favours m0, ptr=1 favours m1
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                if (req0 && (!req1 || !ptr)) begin
                    state_nxt = OWN0;
                end else if (req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i || expire) begin
                    state_nxt = IDLE;
                    ptr_nxt   = 1'b1;
                end
            end
            OWN1: begin
                if (!m1_cyc_i || expire) begin
                    state_nxt = IDLE;
                    ptr_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            ptr   <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    assign s_adr_o = own1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o = own1 ? m1_dat_i : m0_dat_i;
    assign s_sel_o = own1 ? m1_sel_i : m0_sel_i;
    assign s_we_o  = (own0 & m0_we_i) | (own1 & m1_we_i);

    assign s_cyc_o = ((own0 & m0_cyc_i) | (own1 & m1_cyc_i)) & ~expire;
    assign s_stb_o = ((own0 & m0_stb_i) | (own1 & m1_stb_i)) & ~expire;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = own0 & s_ack_i;
    assign m1_ack_o = own1 & s_ack_i;
    assign m0_err_o = own0 & (s_err_i | expire);
    assign m1_err_o = own1 & (s_err_i | expire);

    assign grant_o = own0 ? GNT_M0 : (own1 ? GNT_M1 : GNT_NONE);

endmodule

// File: doc/wb_rr_arbiter2.md
Name: wb_rr_arbiter2

Overview:
Two-master, one-slave Wishbone B3 classic arbiter for the picorv32 Wishbone SoC. It shares a single slave port (e.g. SRAM0) between the CPU data master (m0) and a secondary master (m1: DMA or debug loader). Grants are round-robin and held for a whole bus cycle (CYC), so lock and burst sequences are not split. It sits between the masters and the address decoder or slave inside picorv32_wb_soc, in the wb_clk domain.

Parameters:
AW, 32, address width
DW, 32, data width; select width is DW/8
TIMEOUT_CYCLES, 255, stalled-strobe limit; used only with the optional feature; must be >= 2

Ports:
wb_clk_i  in  1  Wishbone clock
wb_rst_i  in  1  reset; asynchronous, active-high
m0_adr_i / m1_adr_i  in  AW  master address
m0_dat_i / m1_dat_i  in  DW  master write data
m0_sel_i / m1_sel_i  in  DW/8  byte selects
m0_we_i / m1_we_i  in  1  write enable
m0_cyc_i / m1_cyc_i  in  1  cycle request
m0_stb_i / m1_stb_i  in  1  strobe
m0_dat_o / m1_dat_o  out  DW  read data (s_dat_i broadcast)
m0_ack_o / m1_ack_o  out  1  acknowledge, routed to owner only
m0_err_o / m1_err_o  out  1  error, routed to owner only
s_adr_o, s_dat_o, s_sel_o, s_we_o  out  AW/DW/DW/8/1  muxed from owner
s_cyc_o, s_stb_o  out  1  owner's cyc/stb gated by grant
s_dat_i  in  DW  slave read data
s_ack_i, s_err_i  in  1  slave ack/err
grant_o  out  2  one-hot current owner; 00 when idle

Behaviour:
- FSM states: IDLE, OWN0, OWN1. Reset (async) -> IDLE, priority pointer favours m0.
- Reset values: grant_o=00. s_cyc_o, s_stb_o, s_we_o=0. All ack/err outputs 0. s_adr_o/s_dat_o/s_sel_o = m0 inputs (don't-care, not driven to X).
- IDLE: at the clock edge, if exactly one mN_cyc_i=1, go to OWNn. If both are 1, grant the master the pointer favours. With no request, stay in IDLE.
- Arbitration latency: exactly one cycle. The slave sees cyc/stb in the first cycle after the master raises cyc.
- OWNn: slave outputs are combinationally muxed from master n. s_cyc_o=mN_cyc_i and s_stb_o=mN_stb_i. mN_ack_o=s_ack_i, mN_err_o=s_err_i. The other master's ack/err stay 0.
- The grant is held while mN_cyc_i=1, regardless of the other request.
- When mN_cyc_i falls, go to IDLE on that edge and set the pointer to favour the other master. Because s_cyc_o is combinational, it drops in the same cycle as the master's cyc.
- Every ownership change passes through at least one IDLE cycle, including back-to-back cycles by the same master.
- Fairness: while both request continuously, grants strictly alternate m0, m1, m0, ...
- Slave ack/err arriving in IDLE is discarded.
- stb dropped mid-cycle with cyc held: the grant is retained.
- Reset asserted mid-operation: the FSM goes to IDLE immediately (async). Slave cyc/stb and all acks drop in the same cycle; the pointer returns to favouring m0.

Optional Feature:
WB_ARB_TIMEOUT_EN:
- Defined: a counter tracks cycles in OWNn with s_stb_o=1 and s_ack_i=s_err_i=0. It clears on ack, err, or stb low. When it reaches TIMEOUT_CYCLES, the arbiter:
  - asserts mN_err_o for one cycle;
  - forces s_cyc_o/s_stb_o to 0 from that cycle;
  - returns to IDLE next edge, even if mN_cyc_i is still 1;
  - re-arbitrates only after mN_cyc_i has been low for at least one cycle.
- Not defined: no counter; err is pure pass-through and a stalled slave hangs the owner indefinitely.

Decomposition:
- Package wb_arb_pkg holds:
  - state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2);
  - grant constants GNT_NONE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10.
- One natural sub-module, wb_arb_timeout: the stall counter with clear/expire outputs, instantiated only under WB_ARB_TIMEOUT_EN.
- The mux and FSM stay in the top module.

Test Plan:
- m0 only: cyc/stb at t0, write adr=0x0000_0010 dat=0xDEADBEEF, slave acks at t2. Expect s_stb_o at t1, m0_ack_o at t2 only, m1_ack_o=0, grant_o=01, then 00 after m0 drops cyc.
- Both raise cyc in the same cycle after reset. Expect m0 granted first, m1 next, then m0; after 6 single-beat cycles, grant sequence 01,10,01,10,01,10 with one 00 between each.
- m1 owns a 4-beat read (adr 0x100-0x10C) while m0 requests. Expect m0 blocked until m1 cyc falls and m1 to receive all 4 acks. Stray s_ack_i injected in IDLE must appear on neither master.
- wb_rst_i pulsed mid-transaction in OWN1. Expect s_cyc_o=0, grant_o=00 in the same cycle, and the next simultaneous request granted to m0.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks m0. Expect m0_err_o high for exactly one cycle 8 cycles after stb, s_cyc_o=0 thereafter, and m1 able to be granted afterwards.
